mem_req_sequencer: RTL and testbench
====================================

# mem_req_sequencer

Request front-end that sits directly upstream of `memory_rtl` and owns its `wr`/`rd`/`addr`/`wdata` pins. It accepts read and write requests over a valid/ready handshake and buffers them in a small FIFO. It issues one memory access at a time, waits for the memory's `response`, and returns exactly one response per request over a second valid/ready handshake. Out-of-range addresses are rejected locally and never reach the memory.

## Interface
- `ADDR_WIDTH`, default 8: request and memory address width.
- `DATA_WIDTH`, default 32: data width.
- `MEM_SIZE`, default 16: number of valid memory words; legal addresses are 0..MEM_SIZE-1.
- `DEPTH`, default 4: request FIFO entries; must be a power of two, at least 2.
- `TIMEOUT`, default 16: cycles to wait for `mem_response`. Used only when `MEM_REQ_TIMEOUT_EN` is defined.
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: FIFO can accept.
- `req_wr`, in, 1: 1 = write, 0 = read.
- `req_addr`, in, ADDR_WIDTH: word address.
- `req_wdata`, in, DATA_WIDTH: write data.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_wr`, out, 1: echo of the request type.
- `rsp_rdata`, out, DATA_WIDTH: read data; 0 for writes and errors.
- `rsp_err`, out, 1: 1 = out-of-range address or timeout.
- `mem_wr`, out, 1: memory write strobe.
- `mem_rd`, out, 1: memory read strobe.
- `mem_addr`, out, ADDR_WIDTH: memory address.
- `mem_wdata`, out, DATA_WIDTH: memory write data.
- `mem_rdata`, in, DATA_WIDTH: memory read data.
- `mem_response`, in, 1: memory completion pulse.

## Operation
- Reset values: every output is 0, except `req_ready` = 1. FIFO is empty and FSM is in IDLE.
- Request handshake: a request is accepted on an edge where `req_valid && req_ready`.
  - `req_ready = (count != DEPTH)`, registered count.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - When full, `req_ready` is 0. Pop-through to a full FIFO is not permitted.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE → ISSUE when the FIFO is non-empty and the address is legal.
  - Pop the FIFO and load registered `mem_addr`/`mem_wdata`.
  - Assert `mem_wr` or `mem_rd` for exactly one cycle.
- IDLE → RESP when the FIFO is non-empty and `addr >= MEM_SIZE`.
  - Pop the FIFO with no memory strobe.
  - Set `rsp_err` = 1 and `rsp_rdata` = 0.
- ISSUE → WAIT unconditionally; strobes drop to 0.
- WAIT → RESP on `mem_response` = 1.
  - Capture `mem_rdata` for reads; `rsp_rdata` = 0 for writes.
  - `rsp_err` = 0.
- RESP: hold `rsp_valid` and all `rsp_*` outputs stable until `rsp_ready` = 1, then go to IDLE on that edge.
- `mem_response` in any state other than WAIT is ignored.
- Address compare is unsigned, full ADDR_WIDTH. `mem_addr` and `mem_wdata` hold their last values outside ISSUE.
- Asserting `reset` mid-operation returns the block to reset state immediately.
  - FIFO contents, any in-flight access and any pending response are discarded.
  - No response is produced for them.

## Timing
- Memory contract: the memory samples the strobes at the rising edge that ends ISSUE. `mem_response` and `mem_rdata` are valid in the following cycle.
- Empty FIFO, legal request accepted at edge N:
  - IDLE pops at edge N+1; `mem_rd`/`mem_wr` are high for cycle N+1 to N+2.
  - `mem_response` arrives during cycle N+2 to N+3.
  - `rsp_valid` is high from edge N+3.
- Out-of-range request accepted at edge N: `rsp_valid` is high from edge N+1.
- Throughput: at most one request per 4 cycles with `rsp_ready` held at 1 (IDLE → ISSUE → WAIT → RESP).
- Responses return strictly in request order.

## Configuration
- `MEM_REQ_TIMEOUT_EN` defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT` without `mem_response`, go WAIT → RESP with `rsp_err` = 1 and `rsp_rdata` = 0.
  - A `mem_response` arriving later is ignored.
- Not defined: no counter exists and WAIT persists until `mem_response`.

## Structure
- Package `mem_req_pkg` holds:
  - the FSM state enum;
  - the packed request struct {wr, addr, wdata};
  - the packed response struct {wr, rdata, err}.
- Struct widths come from package parameters matching the module defaults.
- One sub-module, `mem_req_fifo`: synchronous DEPTH-entry FIFO with count, full and empty, same clock and reset.

## Test plan
- Reset with `req_valid` high → `req_ready` = 1, `rsp_valid` = 0, all `mem_*` strobes 0.
- Write 0xDEADBEEF to address 3, then read address 3 → `mem_wr` pulses once, the read returns `rsp_rdata` = 0xDEADBEEF and `rsp_err` = 0, and accept-to-`rsp_valid` is 3 cycles.
- Read address 16 with MEM_SIZE = 16 → no `mem_rd` pulse, `rsp_err` = 1, `rsp_rdata` = 0, `rsp_valid` one cycle after accept.
- Hold `rsp_ready` = 0 while pushing 5 requests →
  - `req_ready` drops after the FIFO holds 4 requests;
  - the first response holds stable;
  - releasing `rsp_ready` drains all 5 responses in order.
- With `MEM_REQ_TIMEOUT_EN`, suppress `mem_response` → `rsp_err` = 1 exactly 16 WAIT cycles after ISSUE, and a late `mem_response` is ignored.
- Assert `reset` during WAIT with 2 requests queued → everything clears, and no `rsp_valid` appears after reset is released.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared types for the memory request sequencer: FSM state encoding and
// default-width request/response records.
package mem_req_pkg;

  localparam int ADDR_WIDTH_P = 8;
  localparam int DATA_WIDTH_P = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic                    wr;
    logic [ADDR_WIDTH_P-1:0] addr;
    logic [DATA_WIDTH_P-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic                    wr;
    logic [DATA_WIDTH_P-1:0] rdata;
    logic                    err;
  } rsp_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous DEPTH-entry request FIFO with occupancy count, full and empty.
// Head entry is presented combinationally on rdata_o.
module mem_req_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data-only; occupancy tracking makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mem_req_sequencer.sv
// Request front-end for memory_rtl: FIFO-buffered requests, one access in flight,
// in-order responses, local rejection of out-of-range addresses.
// Optional response watchdog enabled by defining MEM_REQ_TIMEOUT_EN.
module mem_req_sequencer
  import mem_req_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_P,
  parameter int DATA_WIDTH = DATA_WIDTH_P,
  parameter int MEM_SIZE   = 16,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_wr,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_response
);

  localparam int REQ_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("mem_req_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  function automatic logic addr_legal(input logic [ADDR_WIDTH-1:0] a);
    return 64'(a) < 64'(MEM_SIZE);
  endfunction

  logic [REQ_W-1:0]      fifo_wdata, fifo_rdata;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  head_wr;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;

  state_e                state_q, state_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  cur_wr_q, cur_wr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_wr_q, rsp_wr_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  assign req_ready  = (fifo_count != CNT_W'(DEPTH));
  assign fifo_push  = req_valid && !fifo_full;
  assign fifo_wdata = {req_wr, req_addr, req_wdata};
  assign {head_wr, head_addr, head_wdata} = fifo_rdata;

  mem_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;
  // tmo_q counts completed WAIT cycles; the TIMEOUT-th one ends the wait.
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d     = state_q;
    mem_wr_d    = 1'b0;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cur_wr_d    = cur_wr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_wr_d    = rsp_wr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_wr_d = head_wr;
          if (addr_legal(head_addr)) begin
            mem_addr_d  = head_addr;
            mem_wdata_d = head_wdata;
            mem_wr_d    = head_wr;
            mem_rd_d    = !head_wr;
            state_d     = ST_ISSUE;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_wr_d    = head_wr;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef MEM_REQ_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (mem_response) begin
          rsp_valid_d = 1'b1;
          rsp_wr_d    = cur_wr_q;
          rsp_rdata_d = cur_wr_q ? '0 : mem_rdata;
          rsp_err_d   = 1'b0;
          state_d     = ST_RESP;
        end
`ifdef MEM_REQ_TIMEOUT_EN
        else if (tmo_hit) begin
          rsp_valid_d = 1'b1;
          rsp_wr_d    = cur_wr_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cur_wr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cur_wr_q    <= cur_wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef MEM_REQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  assign mem_wr    = mem_wr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_wr    = rsp_wr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Bench for mem_req_sequencer: table of single requests with latency/strobe
// checks, scoreboarded responses, plus backpressure, timeout and reset sequences.
module tb_mem_req_sequencer;
  import mem_req_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_wr, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          mem_wr, mem_rd, mem_response;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_req_sequencer #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .MEM_SIZE (16), .DEPTH (4), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .reset (reset),
    .req_valid (req_valid), .req_ready (req_ready), .req_wr (req_wr),
    .req_addr (req_addr), .req_wdata (req_wdata),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_wr (rsp_wr),
    .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
    .mem_wr (mem_wr), .mem_rd (mem_rd), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_rdata (mem_rdata), .mem_response (mem_response)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   nwr = 0;
  int   nrd = 0;
  rsp_t q_exp[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr) nwr <= nwr + 1;
    if (mem_rd) nrd <= nrd + 1;
  end

  // Memory model: samples strobes at the edge ending ISSUE, answers next cycle.
  logic [DW-1:0] mem_arr [16];
  logic          model_resp = 1'b0;
  logic [DW-1:0] model_rdata = '0;
  logic          suppress = 1'b0;
  logic          late_pulse = 1'b0;

  always @(posedge clk) begin
    model_resp <= 1'b0;
    if (mem_wr) begin
      mem_arr[mem_addr[3:0]] <= mem_wdata;
      if (!suppress) model_resp <= 1'b1;
    end else if (mem_rd) begin
      model_rdata <= mem_arr[mem_addr[3:0]];
      if (!suppress) model_resp <= 1'b1;
    end
  end

  assign mem_response = model_resp | late_pulse;
  assign mem_rdata    = late_pulse ? 32'hBAD0BAD0 : model_rdata;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (q_exp.size() == 0) begin
        check("rsp_unexpected", {30'd0, rsp_wr, rsp_rdata, rsp_err}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        rsp_t e;
        e = q_exp.pop_front();
        check("rsp_data", {30'd0, rsp_wr, rsp_rdata, rsp_err}, {30'd0, e});
      end
    end
  end

  task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input logic push, input rsp_t e, output int acc);
    acc = -1;
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc + 1;
        if (push) q_exp.push_back(e);
        break;
      end
    end
    if (acc < 0) check("send_accept", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int seen);
    seen = -1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = cyc;
        break;
      end
    end
  endtask

  task automatic drain(input string nm);
    for (int t = 0; t < 200 && q_exp.size() != 0; t++) @(negedge clk);
    check(nm, 64'(q_exp.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  vec_t vt [12];

  initial begin
    int   acc, seen, wr0, rd0, vcnt;
    rsp_t e;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc, seen, wr0, rd0, vcnt;
    rsp_t e;
    vt[0]  = '{1'b1, 8'd3,   32'hDEADBEEF, 32'h0,        1'b0, 3};
    vt[1]  = '{1'b0, 8'd3,   32'h0,        32'hDEADBEEF, 1'b0, 3};
    vt[2]  = '{1'b0, 8'd16,  32'h0,        32'h0,        1'b1, 1};
    vt[3]  = '{1'b1, 8'd15,  32'h0000A5A5, 32'h0,        1'b0, 3};
    vt[4]  = '{1'b0, 8'd15,  32'h0,        32'h0000A5A5, 1'b0, 3};
    vt[5]  = '{1'b0, 8'd0,   32'h0,        32'h0,        1'b0, 3};
    vt[6]  = '{1'b1, 8'd255, 32'h00001111, 32'h0,        1'b1, 1};
    vt[7]  = '{1'b0, 8'd255, 32'h0,        32'h0,        1'b1, 1};
    vt[8]  = '{1'b1, 8'd0,   32'h12345678, 32'h0,        1'b0, 3};
    vt[9]  = '{1'b0, 8'd0,   32'h0,        32'h12345678, 1'b0, 3};
    vt[10] = '{1'b0, 8'd3,   32'h0,        32'hDEADBEEF, 1'b0, 3};
    vt[11] = '{1'b1, 8'd16,  32'hFFFFFFFF, 32'h0,        1'b1, 1};
    for (int i = 0; i < 16; i++) mem_arr[i] = '0;

    reset = 1'b1; req_valid = 1'b1; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_rsp", {30'd0, rsp_valid, rsp_wr, rsp_err, rsp_rdata}, 64'd0);
    check("reset_mem", {22'd0, mem_wr, mem_rd, mem_addr, mem_wdata}, 64'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      e   = '{wr: vt[i].wr, rdata: vt[i].exp_rdata, err: vt[i].exp_err};
      wr0 = nwr; rd0 = nrd;
      send(vt[i].wr, vt[i].addr, vt[i].wdata, 1'b1, e, acc);
      wait_rsp(seen);
      check($sformatf("vec%0d_latency", i), 64'(seen - acc), 64'(vt[i].exp_lat));
      drain($sformatf("vec%0d_drain", i));
      check($sformatf("vec%0d_wr_pulses", i), 64'(nwr - wr0), 64'(vt[i].wr && !vt[i].exp_err));
      check($sformatf("vec%0d_rd_pulses", i), 64'(nrd - rd0), 64'(!vt[i].wr && !vt[i].exp_err));
    end

    // Backpressure: five requests with the consumer stalled.
    rsp_ready = 1'b0;
    send(1'b0, 8'd15, 32'h0,        1'b1, '{wr: 1'b0, rdata: 32'h0000A5A5, err: 1'b0}, acc);
    send(1'b1, 8'd7,  32'h00000077, 1'b1, '{wr: 1'b1, rdata: 32'h0,        err: 1'b0}, acc);
    send(1'b0, 8'd7,  32'h0,        1'b1, '{wr: 1'b0, rdata: 32'h00000077, err: 1'b0}, acc);
    send(1'b0, 8'd16, 32'h0,        1'b1, '{wr: 1'b0, rdata: 32'h0,        err: 1'b1}, acc);
    send(1'b0, 8'd0,  32'h0,        1'b1, '{wr: 1'b0, rdata: 32'h12345678, err: 1'b0}, acc);
    @(negedge clk);
    check("bp_full_ready", 64'(req_ready), 64'd0);
    wait_rsp(seen);
    check("bp_first_seen", 64'(seen >= 0), 64'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", k), {30'd0, rsp_valid, rsp_wr, rsp_err, rsp_rdata},
            {30'd0, 1'b1, 1'b0, 1'b0, 32'h0000A5A5});
    end
    check("bp_still_full", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain("bp_drain");

`ifdef MEM_REQ_TIMEOUT_EN
    rsp_ready = 1'b0;
    suppress  = 1'b1;
    rd0 = nrd;
    send(1'b0, 8'd1, 32'h0, 1'b1, '{wr: 1'b0, rdata: 32'h0, err: 1'b1}, acc);
    wait_rsp(seen);
    check("tmo_latency", 64'(seen - acc), 64'(2 + TO));
    check("tmo_rd_pulse", 64'(nrd - rd0), 64'd1);
    @(posedge clk); #1; late_pulse = 1'b1;
    @(posedge clk); #1; late_pulse = 1'b0;
    @(negedge clk);
    check("tmo_late_ignored", {30'd0, rsp_valid, rsp_err, rsp_rdata}, {30'd0, 1'b1, 1'b1, 32'h0});
    rsp_ready = 1'b1;
    drain("tmo_drain");
    late_pulse = 1'b1;
    @(posedge clk); #1; late_pulse = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) vcnt++;
    end
    check("tmo_idle_late", 64'(vcnt), 64'd0);
    suppress = 1'b0;
`endif

    // Reset while an access is in WAIT and two more are queued.
    suppress = 1'b1;
    send(1'b0, 8'd2, 32'h0,        1'b0, '{wr: 1'b0, rdata: 32'h0, err: 1'b0}, acc);
    send(1'b1, 8'd4, 32'h44444444, 1'b0, '{wr: 1'b0, rdata: 32'h0, err: 1'b0}, acc);
    send(1'b0, 8'd5, 32'h0,        1'b0, '{wr: 1'b0, rdata: 32'h0, err: 1'b0}, acc);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", 64'(req_ready), 64'd1);
    check("rst_mid_rsp", {30'd0, rsp_valid, rsp_wr, rsp_err, rsp_rdata}, 64'd0);
    check("rst_mid_mem", {22'd0, mem_wr, mem_rd, mem_addr, mem_wdata}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    suppress = 1'b0;
    vcnt = 0;
    wr0 = nwr; rd0 = nrd;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) vcnt++;
    end
    check("rst_no_rsp", 64'(vcnt), 64'd0);
    check("rst_no_strobe", 64'((nwr - wr0) + (nrd - rd0)), 64'd0);
    @(posedge clk); #1;
    send(1'b0, 8'd4, 32'h0, 1'b1, '{wr: 1'b0, rdata: 32'h0, err: 1'b0}, acc);
    drain("rst_read4_drain");
    send(1'b0, 8'd3, 32'h0, 1'b1, '{wr: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0}, acc);
    drain("rst_read3_drain");

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
